// File: rtl/ctrl_pkg.sv
// Shared types and opcode patterns for the multicycle CPU controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LDI_RD = 4'd3,
    S_LDM_RD = 4'd4,
    S_WB_DI  = 4'd5,
    S_MVR    = 4'd6,
    S_ALU_EX = 4'd7,
    S_ALU_WB = 4'd8,
    S_STM    = 4'd9,
    S_JMP    = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    RFW_ALU  = 2'd0,
    RFW_REG1 = 2'd1,
    RFW_DI   = 2'd2
  } rf_wsrc_t;

  // Opcode class patterns on the top four opcode bits (? = don't care).
  localparam logic [3:0] OP_LDI = 4'b000?;
  localparam logic [3:0] OP_MVR = 4'b0010;
  localparam logic [3:0] OP_ALU = 4'b01??;
  localparam logic [3:0] OP_LDM = 4'b1000;
  localparam logic [3:0] OP_STM = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b101?;
  localparam logic [3:0] OP_HLT = 4'b1111;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_LDI_RD) || (s == S_LDM_RD) || (s == S_STM);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; saturates at LIMIT and flags expiry (LIMIT=0 never expires).
module mem_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != W'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && (cnt == W'(LIMIT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU controller: sequences datapath strobes from the IR opcode,
// with a memory ready handshake, wait timeout, illegal-op flag and retire counter.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] instr_op,
  input  logic                jump_taken,
  input  logic                mem_ready,
  input  logic                run,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_tr,
  output logic                ld_ir,
  output logic                ld_di,
  output logic                ld_tr,
  output logic                ld_alu,
  output logic                ld_pc,
  output logic                ld_czn,
  output logic                pc_src_jump,
  output logic                czn_src_alu,
  output logic                rf_we,
  output logic [1:0]          rf_wsrc,
  output logic                halted,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    instr_retired,
  output logic [3:0]          state_dbg
);

  state_t     state, state_nxt;
  logic       retire;
  logic       tmr_expired;
  logic       in_mem;
  logic [3:0] op4;

  assign op4    = instr_op[OPCODE_W-1 -: 4];
  assign in_mem = is_mem_state(state);

  // Timer restarts whenever an access completes or we leave the memory states.
  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_mem || mem_ready),
    .enable  (in_mem && !mem_ready),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_BOOT;
      instr_retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instr_retired <= instr_retired + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr_tr = 1'b0;
    ld_ir       = 1'b0;
    ld_di       = 1'b0;
    ld_tr       = 1'b0;
    ld_alu      = 1'b0;
    ld_pc       = 1'b0;
    ld_czn      = 1'b0;
    pc_src_jump = 1'b0;
    czn_src_alu = 1'b0;
    rf_we       = 1'b0;
    rf_wsrc     = RFW_ALU;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    case (state)
      S_BOOT: state_nxt = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ld_ir     = 1'b1;
          ld_pc     = 1'b1;
          state_nxt = S_DECODE;
        end else if (tmr_expired) begin
          mem_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end

      S_DECODE: begin
        ld_tr = 1'b1;
        casez (op4)
          OP_LDI:  state_nxt = S_LDI_RD;
          OP_MVR:  state_nxt = S_MVR;
          OP_ALU:  state_nxt = S_ALU_EX;
          OP_LDM:  state_nxt = S_LDM_RD;
          OP_STM:  state_nxt = S_STM;
          OP_JMP:  state_nxt = S_JMP;
          OP_HLT: begin
            retire    = 1'b1;
            state_nxt = S_HALT;
          end
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end

      S_LDI_RD: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ld_di     = 1'b1;
          ld_pc     = 1'b1;
          state_nxt = S_WB_DI;
        end else if (tmr_expired) begin
          mem_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end

      S_LDM_RD: begin
        mem_req     = 1'b1;
        mem_addr_tr = 1'b1;
        if (mem_ready) begin
          ld_di     = 1'b1;
          state_nxt = S_WB_DI;
        end else if (tmr_expired) begin
          mem_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end

      S_WB_DI: begin
        rf_we     = 1'b1;
        rf_wsrc   = RFW_DI;
        ld_czn    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_MVR: begin
        rf_we     = 1'b1;
        rf_wsrc   = RFW_REG1;
        ld_czn    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_ALU_EX: begin
        ld_alu    = 1'b1;
        state_nxt = S_ALU_WB;
      end

      S_ALU_WB: begin
        rf_we       = 1'b1;
        rf_wsrc     = RFW_ALU;
        ld_czn      = 1'b1;
        czn_src_alu = 1'b1;
        retire      = 1'b1;
        state_nxt   = S_FETCH;
      end

      S_STM: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr_tr = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (tmr_expired) begin
          mem_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end

      S_JMP: begin
        if (jump_taken) begin
          ld_pc       = 1'b1;
          pc_src_jump = 1'b1;
        end
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (run) state_nxt = S_FETCH;
      end

      default: state_nxt = S_BOOT;
    endcase
  end

  assign state_dbg = state;

endmodule
